fwd_hazard_unit: RTL and testbench

- Control-side companion to the pipeline's operand forwarding muxes: generates the 2-bit selects those muxes consume and the load-use stall/bubble controls.
- Keeps its own shadow pipeline of destination-register tags for the EX, MEM and WB stages.
- Sits beside the ID/EX pipeline register.
- Selects are registered so they are valid in the same cycle the instruction occupies EX.

---
 rtl/fwd_hazard_unit.sv | 115 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the EX operand muxes.
// Tracks destination tags of in-flight instructions and registers mux selects.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    logic              mem_rw_q, mem_rw_d;
    logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
    logic              wb_rw_q, wb_rw_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hz;
    logic              ex_hit_a, ex_hit_b;
    logic              mem_hit_a, mem_hit_b;

    // Most recent producer wins; $0 is hardwired zero and never forwarded.
    function automatic logic [1:0] pick_sel(
        input logic bub,
        input logic ex_hit,
        input logic mem_hit
    );
        logic [1:0] s;
        s = 2'd0;
        if (!bub) begin
            if (ex_hit)
                s = 2'd1;
            else if (mem_hit)
                s = 2'd2;
        end
        return s;
    endfunction

    always_comb begin
        ex_hit_a  = ex_rw_q && (ex_dest_q != '0) && (ex_dest_q == id_rs);
        ex_hit_b  = ex_rw_q && (ex_dest_q != '0) && (ex_dest_q == id_rt);
        mem_hit_a = mem_rw_q && (mem_dest_q != '0) && (mem_dest_q == id_rs);
        mem_hit_b = mem_rw_q && (mem_dest_q != '0) && (mem_dest_q == id_rt);

        hz = id_valid && ex_mr_q && (ex_hit_a || (id_uses_rt && ex_hit_b));
        stall  = hz && !flush;
        bubble = hz || flush || !id_valid;

        ex_dest_d  = bubble ? '0 : id_dest;
        ex_rw_d    = bubble ? 1'b0 : id_reg_write;
        ex_mr_d    = bubble ? 1'b0 : id_mem_read;
        mem_dest_d = ex_dest_q;
        mem_rw_d   = ex_rw_q;
        wb_dest_d  = mem_dest_q;
        wb_rw_d    = mem_rw_q;

        fwd_a_d = pick_sel(bubble, ex_hit_a, mem_hit_a);
        fwd_b_d = pick_sel(bubble, ex_hit_b, mem_hit_b);

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_dest_q  <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            mem_dest_q <= '0;
            mem_rw_q   <= 1'b0;
            wb_dest_q  <= '0;
            wb_rw_q    <= 1'b0;
            fwd_a_q    <= 2'd0;
            fwd_b_q    <= 2'd0;
            cnt_q      <= '0;
        end else begin
            ex_dest_q  <= ex_dest_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            mem_dest_q <= mem_dest_d;
            mem_rw_q   <= mem_rw_d;
            wb_dest_q  <= wb_dest_d;
            wb_rw_q    <= wb_rw_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            cnt_q      <= cnt_d;
        end
    end

    // The WB tag has no consumer here; it is kept for debug visibility only.
    logic wb_unused;
    assign wb_unused = ^{wb_dest_q, wb_rw_q};

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit.
// A second instance with a 2-bit counter exercises saturation.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble;
    logic [15:0] stall_count;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic       s_stall, s_bubble;
    logic [1:0] s_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .stall(s_stall), .bubble(s_bubble), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] dst, input logic rw,
                         input logic mr, input logic fl);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_dest      = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic nops(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_a", fwd_a_sel, 0);
        chk("rst_b", fwd_b_sel, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_count, 0);
        tick();
        reset = 1'b0;
        nops(2);

        // EX->EX: add $3 ; sub $5,$3,$4
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 4, 1, 5, 1, 0, 0);
        #1;
        chk("exex_stall", stall, 0);
        chk("exex_bubble", bubble, 0);
        tick();
        chk("exex_a", fwd_a_sel, 1);
        chk("exex_b", fwd_b_sel, 0);
        nops(3);

        // MEM->EX: add $3 ; nop ; or $6,$4,$3
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        nops(1);
        drive(1, 4, 3, 1, 6, 1, 0, 0);
        tick();
        chk("memex_a", fwd_a_sel, 0);
        chk("memex_b", fwd_b_sel, 2);
        nops(3);

        // Priority: add $3 ; add $3 ; and $7,$3,$3
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 3, 1, 7, 1, 0, 0);
        tick();
        chk("prio_a", fwd_a_sel, 1);
        chk("prio_b", fwd_b_sel, 1);
        nops(3);

        // Load-use: lw $2 ; add $8,$2,$9
        drive(1, 1, 2, 0, 2, 1, 1, 0);
        tick();
        drive(1, 2, 9, 1, 8, 1, 0, 0);
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        chk("lu_cnt0", stall_count, 0);
        tick();
        chk("lu_stall2", stall, 0);
        chk("lu_bubble2", bubble, 0);
        chk("lu_cnt1", stall_count, 1);
        tick();
        chk("lu_a", fwd_a_sel, 2);
        chk("lu_b", fwd_b_sel, 0);
        chk("lu_cnt_hold", stall_count, 1);
        chk("lu_sat_cnt", s_count, 1);
        nops(3);

        // $0 is never forwarded
        drive(1, 1, 2, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 1, 0, 0);
        tick();
        chk("zero_a", fwd_a_sel, 0);
        chk("zero_b", fwd_b_sel, 0);
        nops(3);

        // Store does not write: no forwarding of its rt
        drive(1, 1, 5, 1, 5, 0, 0, 0);
        tick();
        drive(1, 5, 5, 1, 6, 1, 0, 0);
        tick();
        chk("sw_a", fwd_a_sel, 0);
        chk("sw_b", fwd_b_sel, 0);
        nops(3);

        // lw $2 ; addi $4,$2-in-rt-field with rt unused: no stall
        drive(1, 1, 2, 0, 2, 1, 1, 0);
        tick();
        drive(1, 7, 2, 0, 4, 1, 0, 0);
        #1;
        chk("nort_stall", stall, 0);
        chk("nort_bubble", bubble, 0);
        tick();
        chk("nort_a", fwd_a_sel, 0);
        chk("nort_b", fwd_b_sel, 1);
        chk("nort_cnt", stall_count, 1);
        nops(3);

        // Flush coincident with load-use
        drive(1, 1, 2, 0, 2, 1, 1, 0);
        tick();
        drive(1, 2, 9, 1, 8, 1, 0, 1);
        #1;
        chk("fl_stall", stall, 0);
        chk("fl_bubble", bubble, 1);
        tick();
        chk("fl_cnt", stall_count, 1);
        chk("fl_a", fwd_a_sel, 0);
        nops(3);

        // Five more load-use stalls: 16-bit count reaches 6, 2-bit sticks at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2, 0, 2, 1, 1, 0);
            tick();
            drive(1, 2, 9, 1, 8, 1, 0, 0);
            tick();
            tick();
        end
        chk("sat_main", stall_count, 6);
        chk("sat_small", s_count, 3);
        nops(3);

        // Reset mid-stall with tags populated
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 4, 0, 2, 1, 1, 0);
        tick();
        drive(1, 2, 9, 1, 8, 1, 0, 0);
        #1;
        chk("pre_rst_a", fwd_a_sel, 1);
        chk("pre_rst_stall", stall, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_bubble", bubble, 0);
        chk("mid_rst_a", fwd_a_sel, 0);
        chk("mid_rst_b", fwd_b_sel, 0);
        chk("mid_rst_cnt", stall_count, 0);
        chk("mid_rst_sat", s_count, 0);
        tick();
        reset = 1'b0;
        nops(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
